// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings (icodes, status, register ids), the W bubble value and
// the memory-stage FSM state type.
package y86_pkg;

   localparam logic [3:0] IHALT   = 4'h0;
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;

   localparam logic [1:0] SAOK = 2'd0;
   localparam logic [1:0] SHLT = 2'd1;
   localparam logic [1:0] SADR = 2'd2;
   localparam logic [1:0] SINS = 2'd3;

   localparam logic [3:0] REG_NONE = 4'hF;

   typedef struct packed {
      logic [1:0]  stat;
      logic [3:0]  icode;
      logic [63:0] val_e;
      logic [63:0] val_m;
      logic [3:0]  dst_e;
      logic [3:0]  dst_m;
   } w_reg_t;

   localparam w_reg_t W_BUBBLE = '{stat: SAOK, icode: INOP, val_e: 64'd0, val_m: 64'd0,
                                   dst_e: REG_NONE, dst_m: REG_NONE};

   typedef enum logic {ST_IDLE, ST_WAIT} mem_state_t;

   function automatic logic is_mem_read(input logic [3:0] icode);
      return (icode == IMRMOVQ) || (icode == IPOPQ) || (icode == IRET);
   endfunction

   function automatic logic is_mem_write(input logic [3:0] icode);
      return (icode == IRMMOVQ) || (icode == IPUSHQ) || (icode == ICALL);
   endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 64-bit data memory: combinational read port, synchronous write port.
module dmem_array #(
   parameter int DEPTH = 256,
   parameter int AW    = 8
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [63:0]   wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [63:0]   rd_data
);

   logic [63:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/mem_stage.sv
// Y86-64 memory stage: data-memory access, multi-cycle latency stall and W register.
// Optional macro DMEM_ADR_CHECK_EN flags addresses >= DEPTH as ADR instead of wrapping.
//
// state   | meaning
// IDLE    | no access in flight; single-cycle accesses complete here
// WAIT    | multi-cycle access in flight using latched address/data
module mem_stage
   import y86_pkg::*;
#(
   parameter int DEPTH   = 256,
   parameter int MEM_LAT = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  M_stat,
   input  logic [3:0]  M_icode,
   input  logic        M_cnd,
   input  logic [63:0] M_valE,
   input  logic [63:0] M_valA,
   input  logic [3:0]  M_dstE,
   input  logic [3:0]  M_dstM,
   input  logic        w_stall,
   output logic [63:0] m_valM,
   output logic [1:0]  m_stat,
   output logic        m_stall,
   output logic [1:0]  W_stat,
   output logic [3:0]  W_icode,
   output logic [63:0] W_valE,
   output logic [63:0] W_valM,
   output logic [3:0]  W_dstE,
   output logic [3:0]  W_dstM
);

   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   // The entry cycle is the first of the L cycles, so WAIT starts one below L-1.
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((MEM_LAT > 1) ? (MEM_LAT - 2) : 0);

   mem_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [AW-1:0]    lat_addr_q, lat_addr_d;
   logic [63:0]      lat_data_q, lat_data_d;
   logic             lat_wr_q, lat_wr_d;
   logic             lat_rd_q, lat_rd_d;
   w_reg_t           w_q, w_d;

   logic          op_rd, op_wr, op_mem, addr_ok, access;
   logic [63:0]   op_addr;
   logic          rd_active, wr_en;
   logic [AW-1:0] rd_addr, wr_addr;
   logic [63:0]   wr_data, rd_data;
   logic          unused_bits;

   always_comb begin
      op_rd   = is_mem_read(M_icode);
      op_wr   = is_mem_write(M_icode);
      op_mem  = op_rd | op_wr;
      op_addr = ((M_icode == IPOPQ) || (M_icode == IRET)) ? M_valA : M_valE;
`ifdef DMEM_ADR_CHECK_EN
      addr_ok = (op_addr < 64'(DEPTH));
`else
      addr_ok = 1'b1;
`endif
      access  = op_mem && (M_stat == SAOK) && addr_ok;
      m_stat  = (op_mem && !addr_ok) ? SADR : M_stat;
   end

   assign unused_bits = M_cnd ^ (^op_addr[63:AW]);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         lat_addr_q <= '0;
         lat_data_q <= '0;
         lat_wr_q   <= 1'b0;
         lat_rd_q   <= 1'b0;
         w_q        <= W_BUBBLE;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         lat_addr_q <= lat_addr_d;
         lat_data_q <= lat_data_d;
         lat_wr_q   <= lat_wr_d;
         lat_rd_q   <= lat_rd_d;
         w_q        <= w_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      lat_addr_d = lat_addr_q;
      lat_data_d = lat_data_q;
      lat_wr_d   = lat_wr_q;
      lat_rd_d   = lat_rd_q;
      case (state_q)
         ST_IDLE: begin
            if (access && (MEM_LAT > 1)) begin
               state_d    = ST_WAIT;
               cnt_d      = CNT_LOAD;
               lat_addr_d = op_addr[AW-1:0];
               lat_data_d = M_valA;
               lat_wr_d   = op_wr;
               lat_rd_d   = op_rd;
            end
         end
         ST_WAIT: begin
            cnt_d = (cnt_q == '0) ? '0 : (cnt_q - CNT_W'(1));
            if ((cnt_q == '0) && !w_stall) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      m_stall   = 1'b0;
      rd_active = 1'b0;
      wr_en     = 1'b0;
      rd_addr   = op_addr[AW-1:0];
      wr_addr   = op_addr[AW-1:0];
      wr_data   = M_valA;
      case (state_q)
         ST_IDLE: begin
            rd_active = access && op_rd;
            if (access && (MEM_LAT > 1)) begin
               m_stall = 1'b1;
            end else begin
               wr_en = access && op_wr && !w_stall;
            end
         end
         ST_WAIT: begin
            rd_addr   = lat_addr_q;
            wr_addr   = lat_addr_q;
            wr_data   = lat_data_q;
            rd_active = lat_rd_q;
            m_stall   = !((cnt_q == '0) && !w_stall);
            wr_en     = lat_wr_q && (cnt_q == '0) && !w_stall;
         end
         default: m_stall = 1'b0;
      endcase
      m_valM = rd_active ? rd_data : 64'd0;
   end

   // W hold has priority over bubble insertion.
   always_comb begin
      w_d = w_q;
      if (!w_stall) begin
         if (m_stall) begin
            w_d = W_BUBBLE;
         end else begin
            w_d = '{stat: m_stat, icode: M_icode, val_e: M_valE, val_m: m_valM,
                    dst_e: M_dstE, dst_m: M_dstM};
         end
      end
   end

   dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_dmem (
      .clk     (clk),
      .wr_en   (wr_en && rst_n),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   assign W_stat  = w_q.stat;
   assign W_icode = w_q.icode;
   assign W_valE  = w_q.val_e;
   assign W_valM  = w_q.val_m;
   assign W_dstE  = w_q.dst_e;
   assign W_dstM  = w_q.dst_m;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: one instance with MEM_LAT=1 (a_*) and one with MEM_LAT=3 (b_*).
module tb_mem_stage;
   import y86_pkg::*;

`ifdef DMEM_ADR_CHECK_EN
   localparam bit ADR_CHK = 1'b1;
`else
   localparam bit ADR_CHK = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]  a_stat, b_stat;
   logic [3:0]  a_icode, b_icode, a_dst_e, b_dst_e, a_dst_m, b_dst_m;
   logic [63:0] a_val_e, b_val_e, a_val_a, b_val_a;
   logic        a_cnd, b_cnd, a_wstall, b_wstall;

   logic [63:0] l1_val_m, l3_val_m, l1_w_val_e, l3_w_val_e, l1_w_val_m, l3_w_val_m;
   logic [1:0]  l1_m_stat, l3_m_stat, l1_w_stat, l3_w_stat;
   logic        l1_m_stall, l3_m_stall;
   logic [3:0]  l1_w_icode, l3_w_icode, l1_w_dst_e, l3_w_dst_e, l1_w_dst_m, l3_w_dst_m;

   int n_cmp = 0;
   int n_bad = 0;

   mem_stage #(.DEPTH(256), .MEM_LAT(1)) u_l1 (
      .clk(clk), .rst_n(rst_n), .M_stat(a_stat), .M_icode(a_icode), .M_cnd(a_cnd),
      .M_valE(a_val_e), .M_valA(a_val_a), .M_dstE(a_dst_e), .M_dstM(a_dst_m),
      .w_stall(a_wstall), .m_valM(l1_val_m), .m_stat(l1_m_stat), .m_stall(l1_m_stall),
      .W_stat(l1_w_stat), .W_icode(l1_w_icode), .W_valE(l1_w_val_e), .W_valM(l1_w_val_m),
      .W_dstE(l1_w_dst_e), .W_dstM(l1_w_dst_m));

   mem_stage #(.DEPTH(256), .MEM_LAT(3)) u_l3 (
      .clk(clk), .rst_n(rst_n), .M_stat(b_stat), .M_icode(b_icode), .M_cnd(b_cnd),
      .M_valE(b_val_e), .M_valA(b_val_a), .M_dstE(b_dst_e), .M_dstM(b_dst_m),
      .w_stall(b_wstall), .m_valM(l3_val_m), .m_stat(l3_m_stat), .m_stall(l3_m_stall),
      .W_stat(l3_w_stat), .W_icode(l3_w_icode), .W_valE(l3_w_val_e), .W_valM(l3_w_val_m),
      .W_dstE(l3_w_dst_e), .W_dstM(l3_w_dst_m));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input logic [1:0] st, input logic [3:0] ic, input logic [63:0] ve,
                          input logic [63:0] va, input logic [3:0] de, input logic [3:0] dm);
      a_stat = st; a_icode = ic; a_cnd = 1'b0; a_val_e = ve; a_val_a = va;
      a_dst_e = de; a_dst_m = dm;
   endtask

   task automatic drive_b(input logic [1:0] st, input logic [3:0] ic, input logic [63:0] ve,
                          input logic [63:0] va, input logic [3:0] de, input logic [3:0] dm);
      b_stat = st; b_icode = ic; b_cnd = 1'b1; b_val_e = ve; b_val_a = va;
      b_dst_e = de; b_dst_m = dm;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; a_wstall = 1'b0; b_wstall = 1'b0;
      drive_a(SAOK, INOP, 0, 0, 15, 15);
      drive_b(SAOK, INOP, 0, 0, 15, 15);
      tick; tick;
      n_cmp++; if (l1_w_icode !== 4'd1) begin n_bad++; $display("FAIL rst_l1_icode got %0d want 1", l1_w_icode); end
      n_cmp++; if (l1_w_dst_m !== 4'd15) begin n_bad++; $display("FAIL rst_l1_dstM got %0d want 15", l1_w_dst_m); end
      n_cmp++; if (l3_w_dst_e !== 4'd15) begin n_bad++; $display("FAIL rst_l3_dstE got %0d want 15", l3_w_dst_e); end
      n_cmp++; if (l3_w_stat !== 2'd0) begin n_bad++; $display("FAIL rst_l3_stat got %0d want 0", l3_w_stat); end
      n_cmp++; if (l3_w_val_m !== 64'd0) begin n_bad++; $display("FAIL rst_l3_valM got %h want 0", l3_w_val_m); end
      n_cmp++; if (l3_m_stall !== 1'b0) begin n_bad++; $display("FAIL rst_l3_stall got %0d want 0", l3_m_stall); end
      rst_n = 1'b1;
      tick;
   endtask

   task automatic test_lat1_rw;
      drive_a(SAOK, IRMMOVQ, 5, 64'hDEAD, 15, 15); #1;
      n_cmp++; if (l1_m_stall !== 1'b0) begin n_bad++; $display("FAIL l1_store_stall got %0d want 0", l1_m_stall); end
      n_cmp++; if (l1_val_m !== 64'd0) begin n_bad++; $display("FAIL l1_store_valM got %h want 0", l1_val_m); end
      tick;
      n_cmp++; if (l1_w_icode !== IRMMOVQ) begin n_bad++; $display("FAIL l1_store_Wicode got %0d want 4", l1_w_icode); end
      drive_a(SAOK, IMRMOVQ, 5, 0, 15, 3); #1;
      n_cmp++; if (l1_val_m !== 64'hDEAD) begin n_bad++; $display("FAIL l1_load_valM got %h want dead", l1_val_m); end
      n_cmp++; if (l1_m_stall !== 1'b0) begin n_bad++; $display("FAIL l1_load_stall got %0d want 0", l1_m_stall); end
      tick;
      n_cmp++; if (l1_w_val_m !== 64'hDEAD) begin n_bad++; $display("FAIL l1_load_WvalM got %h want dead", l1_w_val_m); end
      n_cmp++; if (l1_w_dst_m !== 4'd3) begin n_bad++; $display("FAIL l1_load_WdstM got %0d want 3", l1_w_dst_m); end
      drive_a(SAOK, IPOPQ, 99, 5, 4, 6); #1;
      n_cmp++; if (l1_val_m !== 64'hDEAD) begin n_bad++; $display("FAIL l1_pop_valM got %h want dead", l1_val_m); end
      tick;
      n_cmp++; if (l1_w_val_e !== 64'd99) begin n_bad++; $display("FAIL l1_pop_WvalE got %0d want 99", l1_w_val_e); end
      drive_a(SAOK, IOPQ, 123, 5, 2, 15); #1;
      n_cmp++; if (l1_val_m !== 64'd0) begin n_bad++; $display("FAIL l1_opq_valM got %h want 0", l1_val_m); end
      tick;
      n_cmp++; if (l1_w_val_e !== 64'd123) begin n_bad++; $display("FAIL l1_opq_WvalE got %0d want 123", l1_w_val_e); end
      drive_a(SHLT, IMRMOVQ, 5, 0, 15, 3); #1;
      n_cmp++; if (l1_val_m !== 64'd0) begin n_bad++; $display("FAIL l1_hlt_valM got %h want 0", l1_val_m); end
      n_cmp++; if (l1_m_stat !== SHLT) begin n_bad++; $display("FAIL l1_hlt_mstat got %0d want 1", l1_m_stat); end
      tick;
   endtask

   task automatic test_adr;
      logic [1:0] exp_stat;
      exp_stat = ADR_CHK ? SADR : SAOK;
      drive_a(SAOK, IRMMOVQ, 4, 64'h11, 15, 15); tick;
      drive_a(SAOK, IRMMOVQ, 260, 64'd7, 15, 15); #1;
      n_cmp++; if (l1_m_stat !== exp_stat) begin n_bad++; $display("FAIL adr_store_mstat got %0d want %0d", l1_m_stat, exp_stat); end
      tick;
      n_cmp++; if (l1_w_stat !== exp_stat) begin n_bad++; $display("FAIL adr_store_Wstat got %0d want %0d", l1_w_stat, exp_stat); end
      drive_a(SAOK, IMRMOVQ, 4, 0, 15, 1); #1;
      n_cmp++; if (l1_val_m !== (ADR_CHK ? 64'h11 : 64'd7)) begin n_bad++; $display("FAIL adr_mem4 got %h want %h", l1_val_m, ADR_CHK ? 64'h11 : 64'd7); end
      tick;
      drive_a(SAOK, IMRMOVQ, 300, 0, 15, 1); #1;
      n_cmp++; if (l1_m_stat !== exp_stat) begin n_bad++; $display("FAIL adr_load_mstat got %0d want %0d", l1_m_stat, exp_stat); end
      n_cmp++; if (l1_m_stall !== 1'b0) begin n_bad++; $display("FAIL adr_load_stall got %0d want 0", l1_m_stall); end
      tick;
      n_cmp++; if (l1_w_stat !== exp_stat) begin n_bad++; $display("FAIL adr_load_Wstat got %0d want %0d", l1_w_stat, exp_stat); end
      drive_a(SAOK, INOP, 0, 0, 15, 15);
   endtask

   task automatic test_lat3_push;
      drive_b(SAOK, IPUSHQ, 10, 64'h42, 4, 15); #1;
      n_cmp++; if (l3_m_stall !== 1'b1) begin n_bad++; $display("FAIL push_stall_t0 got %0d want 1", l3_m_stall); end
      tick;
      n_cmp++; if (l3_w_icode !== INOP || l3_w_dst_e !== 4'd15) begin n_bad++; $display("FAIL push_bubble1 got icode %0d dstE %0d want 1/15", l3_w_icode, l3_w_dst_e); end
      n_cmp++; if (l3_m_stall !== 1'b1) begin n_bad++; $display("FAIL push_stall_t1 got %0d want 1", l3_m_stall); end
      tick;
      n_cmp++; if (l3_w_icode !== INOP || l3_w_dst_m !== 4'd15) begin n_bad++; $display("FAIL push_bubble2 got icode %0d dstM %0d want 1/15", l3_w_icode, l3_w_dst_m); end
      n_cmp++; if (l3_m_stall !== 1'b0) begin n_bad++; $display("FAIL push_stall_t2 got %0d want 0", l3_m_stall); end
      tick;
      n_cmp++; if (l3_w_icode !== IPUSHQ || l3_w_dst_e !== 4'd4) begin n_bad++; $display("FAIL push_capture got icode %0d dstE %0d want 10/4", l3_w_icode, l3_w_dst_e); end
   endtask

   task automatic test_back_to_back;
      drive_b(SAOK, IMRMOVQ, 10, 0, 15, 2); #1;
      n_cmp++; if (l3_m_stall !== 1'b1) begin n_bad++; $display("FAIL b2b_stall_entry got %0d want 1", l3_m_stall); end
      tick; tick;
      n_cmp++; if (l3_m_stall !== 1'b0) begin n_bad++; $display("FAIL b2b_stall_done got %0d want 0", l3_m_stall); end
      n_cmp++; if (l3_val_m !== 64'h42) begin n_bad++; $display("FAIL b2b_mem10 got %h want 42", l3_val_m); end
      tick;
      n_cmp++; if (l3_w_val_m !== 64'h42 || l3_w_icode !== IMRMOVQ) begin n_bad++; $display("FAIL b2b_W got valM %h icode %0d want 42/5", l3_w_val_m, l3_w_icode); end
   endtask

   task automatic test_wstall;
      drive_b(SAOK, IRMMOVQ, 20, 64'h77, 15, 15);
      b_wstall = 1'b1; #1;
      tick; tick;
      n_cmp++; if (l3_w_icode !== IMRMOVQ) begin n_bad++; $display("FAIL ws_hold_early got icode %0d want 5", l3_w_icode); end
      n_cmp++; if (l3_m_stall !== 1'b1) begin n_bad++; $display("FAIL ws_stall_c0 got %0d want 1", l3_m_stall); end
      tick;
      n_cmp++; if (l3_m_stall !== 1'b1) begin n_bad++; $display("FAIL ws_stall_c1 got %0d want 1", l3_m_stall); end
      tick;
      n_cmp++; if (l3_w_val_m !== 64'h42 || l3_w_icode !== IMRMOVQ) begin n_bad++; $display("FAIL ws_hold_late got valM %h icode %0d want 42/5", l3_w_val_m, l3_w_icode); end
      b_wstall = 1'b0; #1;
      n_cmp++; if (l3_m_stall !== 1'b0) begin n_bad++; $display("FAIL ws_release_stall got %0d want 0", l3_m_stall); end
      tick;
      n_cmp++; if (l3_w_icode !== IRMMOVQ || l3_w_val_e !== 64'd20) begin n_bad++; $display("FAIL ws_capture got icode %0d valE %0d want 4/20", l3_w_icode, l3_w_val_e); end
      drive_b(SAOK, IMRMOVQ, 20, 0, 15, 2);
      tick; tick;
      n_cmp++; if (l3_val_m !== 64'h77) begin n_bad++; $display("FAIL ws_mem20 got %h want 77", l3_val_m); end
      tick;
   endtask

   task automatic test_reset_mid;
      drive_b(SAOK, IRMMOVQ, 30, 64'h99, 15, 15);
      tick; tick; tick;
      drive_b(SAOK, ICALL, 30, 64'h1234, 4, 15);
      tick; tick;
      rst_n = 1'b0;
      tick;
      n_cmp++; if (l3_w_icode !== INOP || l3_w_dst_e !== 4'd15 || l3_w_val_e !== 64'd0) begin n_bad++; $display("FAIL rmid_W got icode %0d dstE %0d valE %0d want 1/15/0", l3_w_icode, l3_w_dst_e, l3_w_val_e); end
      drive_b(SAOK, INOP, 0, 0, 15, 15);
      rst_n = 1'b1; #1;
      n_cmp++; if (l3_m_stall !== 1'b0) begin n_bad++; $display("FAIL rmid_stall got %0d want 0", l3_m_stall); end
      tick;
      drive_b(SAOK, IMRMOVQ, 30, 0, 15, 1);
      tick; tick;
      n_cmp++; if (l3_val_m !== 64'h99) begin n_bad++; $display("FAIL rmid_mem30 got %h want 99", l3_val_m); end
      tick;
      n_cmp++; if (l3_w_val_m !== 64'h99) begin n_bad++; $display("FAIL rmid_WvalM got %h want 99", l3_w_val_m); end
   endtask

   initial begin
      test_reset;
      test_lat1_rw;
      test_adr;
      test_lat3_push;
      test_back_to_back;
      test_wstall;
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout reached");
      $fatal(1);
   end

endmodule
